// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control FSM and the ALU control decoder.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_MEM_ADDR  = 4'd3,
        S_MEM_READ  = 4'd4,
        S_MEM_WB    = 4'd5,
        S_MEM_WRITE = 4'd6,
        S_EXECUTE   = 4'd7,
        S_R_WB      = 4'd8,
        S_BRANCH    = 4'd9,
        S_JUMP      = 4'd10,
        S_ERROR     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BEQ   = 2'b01;
    localparam logic [1:0] ALUOP_ARITH = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_start;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational map from FSM state to the datapath strobe bundle.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t i_state,
    input  logic   i_mem_ready,
    output ctrl_t  o_ctrl
);

    always_comb begin
        o_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                o_ctrl.mem_read  = 1'b1;
                o_ctrl.alu_src_b = SRCB_FOUR;
                o_ctrl.alu_start = 1'b1;
                // IR load and PC+4 commit only in the cycle the fetch completes
                o_ctrl.ir_write  = i_mem_ready;
                o_ctrl.pc_write  = i_mem_ready;
            end
            S_DECODE: begin
                o_ctrl.alu_src_b = SRCB_IMMSH;
                o_ctrl.alu_start = 1'b1;
            end
            S_MEM_ADDR: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_src_b = SRCB_IMM;
                o_ctrl.alu_start = 1'b1;
            end
            S_MEM_READ: begin
                o_ctrl.mem_read = 1'b1;
                o_ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                o_ctrl.mem_write = 1'b1;
                o_ctrl.i_or_d    = 1'b1;
            end
            S_EXECUTE: begin
                o_ctrl.alu_src_a = 1'b1;
                o_ctrl.alu_op    = ALUOP_ARITH;
                o_ctrl.alu_start = 1'b1;
            end
            S_R_WB: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                o_ctrl.alu_src_a     = 1'b1;
                o_ctrl.alu_op        = ALUOP_BEQ;
                o_ctrl.pc_write_cond = 1'b1;
                o_ctrl.pc_source     = PCSRC_ALUOUT;
                o_ctrl.alu_start     = 1'b1;
            end
            S_JUMP: begin
                o_ctrl.pc_write  = 1'b1;
                o_ctrl.pc_source = PCSRC_JUMP;
            end
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: state sequencing, sticky error capture and retired-instruction count.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [5:0]  i_opcode,
    input  logic        i_mem_ready,
    input  logic        i_err_illegal_func_code,
    input  logic        i_err_illegal_alu_op,
    output logic        o_pc_write,
    output logic        o_pc_write_cond,
    output logic        o_i_or_d,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_ir_write,
    output logic        o_mem_to_reg,
    output logic        o_reg_dst,
    output logic        o_reg_write,
    output logic        o_alu_src_a,
    output logic [1:0]  o_alu_src_b,
    output logic [1:0]  o_pc_source,
    output logic [1:0]  o_alu_op,
    output logic        o_alu_start,
    output logic        o_error,
    output logic [5:0]  o_err_opcode,
    output logic [31:0] o_instr_count
);

    state_t      r_state;
    logic [5:0]  r_err_opcode;
    logic [31:0] r_instr_count;
    ctrl_t       w_ctrl;
    logic        w_alu_err;

    mips_ctrl_decode u_decode (
        .i_state     (r_state),
        .i_mem_ready (i_mem_ready),
        .o_ctrl      (w_ctrl)
    );

    // The ALU-control fault applies to every state that drives the ALU and beats mem_ready
    assign w_alu_err = w_ctrl.alu_start & i_err_illegal_alu_op;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_err_opcode  <= '0;
            r_instr_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (w_alu_err) begin
                        r_state      <= S_ERROR;
                        r_err_opcode <= i_opcode;
                    end else if (i_mem_ready) begin
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_alu_err) begin
                        r_state      <= S_ERROR;
                        r_err_opcode <= i_opcode;
                    end else begin
                        case (i_opcode)
                            OP_RTYPE:     r_state <= S_EXECUTE;
                            OP_LW, OP_SW: r_state <= S_MEM_ADDR;
                            OP_BEQ:       r_state <= S_BRANCH;
                            OP_J:         r_state <= S_JUMP;
                            default: begin
                                r_state      <= S_ERROR;
                                r_err_opcode <= i_opcode;
                            end
                        endcase
                    end
                end
                S_MEM_ADDR: begin
                    if (w_alu_err) begin
                        r_state      <= S_ERROR;
                        r_err_opcode <= i_opcode;
                    end else if (i_opcode == OP_LW) begin
                        r_state <= S_MEM_READ;
                    end else begin
                        r_state <= S_MEM_WRITE;
                    end
                end
                S_MEM_READ: if (i_mem_ready) r_state <= S_MEM_WB;
                S_MEM_WB: begin
                    r_state       <= S_FETCH;
                    r_instr_count <= r_instr_count + 32'd1;
                end
                S_MEM_WRITE: begin
                    if (i_mem_ready) begin
                        r_state       <= S_FETCH;
                        r_instr_count <= r_instr_count + 32'd1;
                    end
                end
                S_EXECUTE: begin
                    if (w_alu_err || i_err_illegal_func_code) begin
                        r_state      <= S_ERROR;
                        r_err_opcode <= i_opcode;
                    end else begin
                        r_state <= S_R_WB;
                    end
                end
                S_R_WB, S_JUMP: begin
                    r_state       <= S_FETCH;
                    r_instr_count <= r_instr_count + 32'd1;
                end
                S_BRANCH: begin
                    if (w_alu_err) begin
                        r_state      <= S_ERROR;
                        r_err_opcode <= i_opcode;
                    end else begin
                        r_state       <= S_FETCH;
                        r_instr_count <= r_instr_count + 32'd1;
                    end
                end
                S_ERROR: r_state <= S_ERROR;
                default: r_state <= S_ERROR;
            endcase
        end
    end

    assign o_pc_write      = w_ctrl.pc_write;
    assign o_pc_write_cond = w_ctrl.pc_write_cond;
    assign o_i_or_d        = w_ctrl.i_or_d;
    assign o_mem_read      = w_ctrl.mem_read;
    assign o_mem_write     = w_ctrl.mem_write;
    assign o_ir_write      = w_ctrl.ir_write;
    assign o_mem_to_reg    = w_ctrl.mem_to_reg;
    assign o_reg_dst       = w_ctrl.reg_dst;
    assign o_reg_write     = w_ctrl.reg_write;
    assign o_alu_src_a     = w_ctrl.alu_src_a;
    assign o_alu_src_b     = w_ctrl.alu_src_b;
    assign o_pc_source     = w_ctrl.pc_source;
    assign o_alu_op        = w_ctrl.alu_op;
    assign o_alu_start     = w_ctrl.alu_start;
    assign o_error         = (r_state == S_ERROR);
    assign o_err_opcode    = r_err_opcode;
    assign o_instr_count   = r_instr_count;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle MIPS main control FSM.
module tb_mips_multicycle_control;
    import mips_ctrl_pkg::*;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        err_func;
    logic        err_aluop;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, alu_start, error;
    logic [1:0]  alu_src_b, pc_source, alu_op;
    logic [5:0]  err_opcode;
    logic [31:0] instr_count;

    int vectors    = 0;
    int miscompares = 0;

    mips_multicycle_control dut (
        .i_clk                   (clk),
        .i_rst                   (rst),
        .i_opcode                (opcode),
        .i_mem_ready             (mem_ready),
        .i_err_illegal_func_code (err_func),
        .i_err_illegal_alu_op    (err_aluop),
        .o_pc_write              (pc_write),
        .o_pc_write_cond         (pc_write_cond),
        .o_i_or_d                (i_or_d),
        .o_mem_read              (mem_read),
        .o_mem_write             (mem_write),
        .o_ir_write              (ir_write),
        .o_mem_to_reg            (mem_to_reg),
        .o_reg_dst               (reg_dst),
        .o_reg_write             (reg_write),
        .o_alu_src_a             (alu_src_a),
        .o_alu_src_b             (alu_src_b),
        .o_pc_source             (pc_source),
        .o_alu_op                (alu_op),
        .o_alu_start             (alu_start),
        .o_error                 (error),
        .o_err_opcode            (err_opcode),
        .o_instr_count           (instr_count)
    );

    // Strobe bundle in the order {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0], pc_source[1:0], alu_op[1:0], alu_start}
    logic [16:0] strobes;
    assign strobes = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
                      alu_op, alu_start};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
        $display("vector %0d %s observed=0x%0h expected=0x%0h", vectors, tag, observed, expected);
    endtask

    initial begin
        int ir_cnt;
        int mw_cnt;
        int bad_cycles;
        logic [9:0] ready_pat;

        rst = 1'b1; opcode = OP_LW; mem_ready = 1'b1; err_func = 1'b0; err_aluop = 1'b0;
        repeat (2) tick();
        check("reset_state",   32'(dut.r_state), 32'(S_IDLE));
        check("reset_strobes", 32'(strobes), 32'h0);
        check("reset_count",   instr_count, 32'h0);
        check("reset_err",     32'({error, err_opcode}), 32'h0);

        // lw, mem_ready high: IDLE one cycle, then five states
        rst = 1'b0;
        check("idle_hold", 32'(dut.r_state), 32'(S_IDLE));
        tick();
        check("lw_fetch_state", 32'(dut.r_state), 32'(S_FETCH));
        check("lw_fetch_strb", 32'(strobes), 32'b1_0_0_1_0_1_0_0_0_0_01_00_00_1);
        tick();
        check("lw_decode_strb", 32'(strobes), 32'b0_0_0_0_0_0_0_0_0_0_11_00_00_1);
        tick();
        check("lw_memaddr_strb", 32'(strobes), 32'b0_0_0_0_0_0_0_0_0_1_10_00_00_1);
        tick();
        check("lw_memread_strb", 32'(strobes), 32'b0_0_1_1_0_0_0_0_0_0_00_00_00_0);
        tick();
        check("lw_memwb_strb", 32'(strobes), 32'b0_0_0_0_0_0_1_0_1_0_00_00_00_0);
        check("lw_memwb_count", instr_count, 32'd0);
        opcode = OP_RTYPE;
        tick();
        check("lw_retire_count", instr_count, 32'd1);
        check("lw_back_fetch", 32'(dut.r_state), 32'(S_FETCH));

        // R-type, beq, j back to back: 4 + 3 + 3 cycles
        tick(); tick();
        check("r_execute_strb", 32'(strobes), 32'b0_0_0_0_0_0_0_0_0_1_00_00_10_1);
        tick();
        check("r_rwb_strb", 32'(strobes), 32'b0_0_0_0_0_0_0_1_1_0_00_00_00_0);
        opcode = OP_BEQ;
        tick(); tick(); tick();
        check("beq_branch_strb", 32'(strobes), 32'b0_1_0_0_0_0_0_0_0_1_00_01_01_1);
        opcode = OP_J;
        tick(); tick(); tick();
        check("j_jump_strb", 32'(strobes), 32'b1_0_0_0_0_0_0_0_0_0_00_10_00_0);
        tick();
        check("rbj_count", instr_count, 32'd4);
        check("rbj_state", 32'(dut.r_state), 32'(S_FETCH));

        // sw with three wait cycles in FETCH and in MEM_WRITE
        opcode = OP_SW;
        ready_pat = 10'b1000111000;
        ir_cnt = 0; mw_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            mem_ready = ready_pat[i];
            #1;
            if (ir_write) ir_cnt++;
            if (mem_write) mw_cnt++;
            tick();
        end
        mem_ready = 1'b1;
        check("sw_ir_write_once", 32'(ir_cnt), 32'd1);
        check("sw_mem_write_cyc", 32'(mw_cnt), 32'd4);
        check("sw_count", instr_count, 32'd5);
        check("sw_state", 32'(dut.r_state), 32'(S_FETCH));

        // illegal opcode in DECODE: sticky ERROR, frozen count
        opcode = 6'b001000;
        tick(); tick();
        check("illop_state", 32'(dut.r_state), 32'(S_ERROR));
        check("illop_error", 32'(error), 32'd1);
        check("illop_err_opcode", 32'(err_opcode), 32'h08);
        opcode = OP_J;
        bad_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (strobes !== 17'h0 || instr_count !== 32'd5 || error !== 1'b1 || err_opcode !== 6'h08)
                bad_cycles++;
        end
        check("illop_frozen", 32'(bad_cycles), 32'd0);

        // err_illegal_func_code in EXECUTE
        rst = 1'b1; tick(); rst = 1'b0;
        check("rst_clears_count", instr_count, 32'd0);
        opcode = OP_RTYPE;
        tick(); tick(); tick();
        check("func_in_execute", 32'(dut.r_state), 32'(S_EXECUTE));
        err_func = 1'b1;
        tick();
        err_func = 1'b0;
        check("func_err_state", 32'(dut.r_state), 32'(S_ERROR));
        check("func_err_regwrite", 32'(reg_write), 32'd0);
        check("func_err_opcode", 32'({error, err_opcode}), 32'h40);

        // err_illegal_alu_op in MEM_ADDR
        rst = 1'b1; tick(); rst = 1'b0;
        opcode = OP_LW;
        tick(); tick(); tick();
        err_aluop = 1'b1;
        tick();
        err_aluop = 1'b0;
        check("aluop_err_state", 32'(dut.r_state), 32'(S_ERROR));
        check("aluop_err_opcode", 32'(err_opcode), 32'h23);
        tick();
        check("aluop_no_wb", 32'({reg_write, instr_count[3:0]}), 32'h0);

        // error flag together with mem_ready in FETCH: error wins
        rst = 1'b1; tick(); rst = 1'b0;
        opcode = OP_SW;
        tick();
        err_aluop = 1'b1; mem_ready = 1'b1;
        tick();
        err_aluop = 1'b0;
        check("fetch_err_wins", 32'(dut.r_state), 32'(S_ERROR));
        check("fetch_err_opcode", 32'(err_opcode), 32'h2B);

        // asynchronous reset during MEM_READ
        rst = 1'b1; tick(); rst = 1'b0;
        opcode = OP_LW;
        tick(); tick(); tick(); tick();
        check("abort_in_memread", 32'(dut.r_state), 32'(S_MEM_READ));
        #2 rst = 1'b1;
        #1;
        check("abort_async_strb", 32'(strobes), 32'h0);
        check("abort_async_state", 32'(dut.r_state), 32'(S_IDLE));
        check("abort_count", instr_count, 32'd0);
        rst = 1'b0;
        tick();
        check("abort_refetch", 32'(dut.r_state), 32'(S_FETCH));

        // counter wrap
        force dut.r_instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_instr_count;
        #1;
        check("wrap_preload", instr_count, 32'hFFFF_FFFF);
        opcode = OP_J;
        tick(); tick(); tick();
        check("wrap_count", instr_count, 32'h0);
        check("wrap_state", 32'(dut.r_state), 32'(S_FETCH));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=stalled expected=finish");
        $fatal(1, "timeout");
    end

endmodule
